md_sequencer: RTL and testbench

//  Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
//  - Accepts one MD op per cycle from the E-stage controller and latches its operands.
//  - Times the MULT/DIV latency with a down-counter.
//  - Owns the HI/LO registers and serves reads of them.
//  - Drives md_stall, which the stall unit ORs into the pipeline stall (freezes PC/D, bubbles E).

---
 rtl/md_sequencer_pkg.sv | 54 +++++
 rtl/md_lat_cnt.sv | 35 +++
 rtl/md_sequencer.sv | 113 +++++++++++
 tb/tb_md_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/md_sequencer_pkg.sv
// Shared op codes, counter width and decode helpers for the MD sequencer.
// Define MDU_MADD_EN to decode the madd/maddu/msub/msubu accumulate ops.
package md_sequencer_pkg;

  localparam int unsigned MdLatW = 4;

  typedef enum logic [3:0] {
    MdNone  = 4'd0,
    MdMult  = 4'd1,
    MdMultu = 4'd2,
    MdDiv   = 4'd3,
    MdDivu  = 4'd4,
    MdMthi  = 4'd5,
    MdMtlo  = 4'd6,
    MdMfhi  = 4'd7,
    MdMflo  = 4'd8,
    MdMadd  = 4'd9,
    MdMaddu = 4'd10,
    MdMsub  = 4'd11,
    MdMsubu = 4'd12
  } md_op_e;

  // Unknown codes, and accumulate codes in the default build, collapse to MdNone.
  function automatic md_op_e md_decode(input logic [3:0] sel);
    md_op_e op;
    case (sel)
      4'd1:    op = MdMult;
      4'd2:    op = MdMultu;
      4'd3:    op = MdDiv;
      4'd4:    op = MdDivu;
      4'd5:    op = MdMthi;
      4'd6:    op = MdMtlo;
      4'd7:    op = MdMfhi;
      4'd8:    op = MdMflo;
`ifdef MDU_MADD_EN
      4'd9:    op = MdMadd;
      4'd10:   op = MdMaddu;
      4'd11:   op = MdMsub;
      4'd12:   op = MdMsubu;
`endif
      default: op = MdNone;
    endcase
    return op;
  endfunction

  function automatic logic md_is_start(input md_op_e op);
    return op inside {MdMult, MdMultu, MdDiv, MdDivu, MdMadd, MdMaddu, MdMsub, MdMsubu};
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return op inside {MdDiv, MdDivu};
  endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Loadable latency down-counter: busy while non-zero, done on the final busy cycle.
module md_lat_cnt
  import md_sequencer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [MdLatW-1:0] load_val_i,
  output logic              busy_o,
  output logic              done_o
);

  logic [MdLatW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == MdLatW'(1));

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; MDU_MADD_EN adds multiply-accumulate ops.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int unsigned Width  = 32,
  parameter int unsigned MulLat = 5,
  parameter int unsigned DivLat = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       md_sel_i,
  input  logic [Width-1:0] d1_i,
  input  logic [Width-1:0] d2_i,
  input  logic             d_is_md_i,
  output logic             busy_o,
  output logic             md_stall_o,
  output logic [Width-1:0] md_out_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  md_op_e            op_in, op_q, op_d;
  logic [Width-1:0]  a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic              start, load, busy, done, prod_signed;
  logic [MdLatW-1:0] lat_val;
  logic [2*Width-1:0] a_ext, b_ext, prod;
  logic signed [Width-1:0] sa, sb;
  logic [Width-1:0]  quo_s, rem_s, quo_u, rem_u;

  assign op_in   = md_decode(md_sel_i);
  assign start   = md_is_start(op_in);
  assign load    = start & ~busy;
  assign lat_val = md_is_div(op_in) ? MdLatW'(DivLat) : MdLatW'(MulLat);

  md_lat_cnt u_lat_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .load_val_i (lat_val),
    .busy_o     (busy),
    .done_o     (done)
  );

  // Full 2W-bit product from sign- or zero-extended latched operands.
  assign prod_signed = op_q inside {MdMult, MdMadd, MdMsub};
  assign a_ext = {{Width{prod_signed & a_q[Width-1]}}, a_q};
  assign b_ext = {{Width{prod_signed & b_q[Width-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  assign sa    = a_q;
  assign sb    = b_q;
  assign quo_s = sa / sb;
  assign rem_s = sa % sb;
  assign quo_u = a_q / b_q;
  assign rem_u = a_q % b_q;

  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    op_d = op_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (load) begin
      a_d  = d1_i;
      b_d  = d2_i;
      op_d = op_in;
    end
    if (done) begin
      case (op_q)
        MdMult, MdMultu: {hi_d, lo_d} = prod;
        MdDiv:  if (b_q != '0) begin lo_d = quo_s; hi_d = rem_s; end
        MdDivu: if (b_q != '0) begin lo_d = quo_u; hi_d = rem_u; end
`ifdef MDU_MADD_EN
        MdMadd, MdMaddu: {hi_d, lo_d} = {hi_q, lo_q} + prod;
        MdMsub, MdMsubu: {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
        default: ;
      endcase
    end else if (!busy) begin
      // Moves only land when idle; anything arriving while busy is dropped.
      if (op_in == MdMthi) hi_d = d1_i;
      if (op_in == MdMtlo) lo_d = d1_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= MdNone;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      op_q <= op_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    md_out_o = '0;
    if (op_in == MdMfhi) md_out_o = hi_q;
    if (op_in == MdMflo) md_out_o = lo_q;
  end

  assign md_stall_o = d_is_md_i & (start | busy);
  assign busy_o     = busy;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cases then randomized ops against a HI/LO model.
module tb_md_sequencer;

  localparam int unsigned MulLat = 5;
  localparam int unsigned DivLat = 10;

  logic        clk, rst, d_is_md, busy, md_stall;
  logic [3:0]  md_sel;
  logic [31:0] d1, d2, md_out, hi, lo;

  logic [31:0] hi_m, lo_m;
  int n_asrt, n_fail;

  md_sequencer #(
    .Width  (32),
    .MulLat (MulLat),
    .DivLat (DivLat)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .md_sel_i   (md_sel),
    .d1_i       (d1),
    .d2_i       (d2),
    .d_is_md_i  (d_is_md),
    .busy_o     (busy),
    .md_stall_o (md_stall),
    .md_out_o   (md_out),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_start(input logic [3:0] sel);
`ifdef MDU_MADD_EN
    return (sel >= 4'd1 && sel <= 4'd4) || (sel >= 4'd9 && sel <= 4'd12);
`else
    return sel >= 4'd1 && sel <= 4'd4;
`endif
  endfunction

  function automatic logic [31:0] exp_out(input logic [3:0] sel, input logic [31:0] h,
                                          input logic [31:0] l);
    if (sel == 4'd7) return h;
    if (sel == 4'd8) return l;
    return 32'd0;
  endfunction

  // Architectural effect of one op on the HI/LO model; returns its busy length.
  function automatic int model_step(input logic [3:0] sel, input logic [31:0] a,
                                    input logic [31:0] b);
    longint sa, sb, na, nb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (sel)
      4'd1: begin p = sa * sb; {hi_m, lo_m} = p; return MulLat; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = p; return MulLat; end
      4'd3: begin
        if (b != 0) begin
          na = (sa < 0) ? -sa : sa;
          nb = (sb < 0) ? -sb : sb;
          q = na / nb;
          r = na % nb;
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          lo_m = q[31:0];
          hi_m = r[31:0];
        end
        return DivLat;
      end
      4'd4: begin
        if (b != 0) begin lo_m = a / b; hi_m = a % b; end
        return DivLat;
      end
      4'd5: begin hi_m = a; return 0; end
      4'd6: begin lo_m = a; return 0; end
`ifdef MDU_MADD_EN
      4'd9, 4'd11: begin
        p = sa * sb;
        {hi_m, lo_m} = (sel == 4'd9) ? {hi_m, lo_m} + p : {hi_m, lo_m} - p;
        return MulLat;
      end
      4'd10, 4'd12: begin
        p = {32'd0, a} * {32'd0, b};
        {hi_m, lo_m} = (sel == 4'd10) ? {hi_m, lo_m} + p : {hi_m, lo_m} - p;
        return MulLat;
      end
`endif
      default: return 0;
    endcase
  endfunction

  // Issue one op at a negedge, then track busy length, stall and HI/LO through completion.
  task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic dm, input bit viol);
    logic [31:0] hi_old, lo_old;
    int lat, n;
    @(negedge clk);
    md_sel = sel; d1 = a; d2 = b; d_is_md = dm;
    #1;
    check("issue_md_out", md_out, exp_out(sel, hi_m, lo_m));
    check("issue_stall", md_stall, dm & is_start(sel));
    hi_old = hi_m;
    lo_old = lo_m;
    lat = model_step(sel, a, b);
    @(negedge clk);
    md_sel = 4'd0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      n++;
      check("busy_hi_hold", hi, hi_old);
      check("busy_lo_hold", lo, lo_old);
      if (viol) begin
        md_sel = 4'($urandom_range(0, 15));
        d1 = $urandom;
        d2 = $urandom;
      end
      #1;
      check("busy_stall", md_stall, dm);
      check("busy_md_out", md_out, exp_out(md_sel, hi_old, lo_old));
      @(negedge clk);
      md_sel = 4'd0;
    end
    check("busy_cycles", 64'(n), 64'(lat));
    check("hi", hi, hi_m);
    check("lo", lo, lo_m);
    d_is_md = 1'b0;
  endtask

  initial begin
    logic [3:0]  rs;
    logic [31:0] ra, rb;
    n_asrt = 0;
    n_fail = 0;
    rst = 1'b1; md_sel = 4'd0; d1 = '0; d2 = '0; d_is_md = 1'b0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(negedge clk);
    d_is_md = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", md_stall, 1'b0);
    check("rst_md_out", md_out, 32'd0);
    rst = 1'b0;
    d_is_md = 1'b0;

    run_op(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFF1);
    run_op(4'd4, 32'd7, 32'd2, 1'b0, 1'b0);
    check("divu_lo_const", lo, 32'd3);
    check("divu_hi_const", hi, 32'd1);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);
    run_op(4'd5, 32'h1234, 32'd0, 1'b1, 1'b0);
    run_op(4'd6, 32'h5678, 32'd0, 1'b1, 1'b0);
    run_op(4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op(4'd3, 32'd99, 32'd0, 1'b0, 1'b0);
    check("div0_hi_const", hi, 32'h1234);
    check("div0_lo_const", lo, 32'h5678);
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Reset mid-division: state clears asynchronously, then a mult completes normally.
    @(negedge clk);
    md_sel = 4'd3; d1 = 32'd100; d2 = 32'd7;
    @(negedge clk);
    md_sel = 4'd0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op(4'd1, 32'd6, 32'hFFFF_FFFE, 1'b1, 1'b0);

    run_op(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    run_op(4'd9, 32'd1, 32'd1, 1'b1, 1'b0);
`ifdef MDU_MADD_EN
    check("madd_hi_const", hi, 32'd1);
    check("madd_lo_const", lo, 32'd0);
`else
    check("madd_hi_const", hi, 32'd0);
    check("madd_lo_const", lo, 32'hFFFF_FFFF);
`endif

    for (int k = 0; k < 60; k++) begin
      rs = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      run_op(rs, ra, rb, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
